vec_round_cipher: RTL and testbench
===================================

# vec_round_cipher

Iterative per-lane byte cipher that sits directly downstream of the scalar-to-vector broadcast stage. It accepts a 64-bit data block plus the 64-bit broadcast key vector (eight identical 8-bit lanes in normal use, though any lane pattern is legal). It applies ROUNDS rounds of a selectable byte-wise operation, one round per clock, and returns the result over a valid/ready handshake. Only one block is processed at a time; the unit is not pipelined.

## Interface
- ROUNDS, default 4: number of rounds per block; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a block on data_in/key_vec/mode.
- in_ready  output  1  unit can accept; equals (state == IDLE).
- data_in  input  64  plaintext block; lane i = bits [8i+7:8i].
- key_vec  input  64  broadcast key vector from the upstream broadcast stage.
- mode  input  2  operation select: 00 XOR, 01 ADD, 10 SUB, 11 ROTL.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- data_out  output  64  working register, always driven.
- busy  output  1  high when state != IDLE.

## Operation
- Three states:
  - IDLE: in_ready=1.
  - RUN: round counter r counts 0..ROUNDS-1.
  - DONE: out_valid=1.
- Accept: on a rising edge with state IDLE and in_valid=1:
  - work ← data_in, key ← key_vec, mode_q ← mode, r ← 0, state ← RUN.
  - key and mode are captured here; changes on the inputs afterwards are ignored.
- Each edge in RUN, every lane i updates as work_i ← op(work_i, kr_i), where kr_i = (key_i + r) mod 256.
  - XOR: work_i ^ kr_i.
  - ADD: (work_i + kr_i) mod 256.
  - SUB: (work_i − kr_i) mod 256, two's-complement wrap.
  - ROTL: rotate work_i left by kr_i[2:0]; 0 means unchanged.
- Counter: after the round with r = ROUNDS−1, state ← DONE; otherwise r ← r+1.
- Lanes are independent. No carry or bit crosses a byte boundary.
- DONE: data_out is held stable. On an edge with out_ready=1, state ← IDLE.
- in_valid is ignored outside IDLE. There is no same-cycle result-out/accept-in; IDLE is always re-entered first.
- data_out keeps the last result in IDLE until the next accept overwrites it.
- Reset (asynchronous, immediate, regardless of state):
  - state=IDLE, work=0, key=0, mode_q=0, r=0.
  - Any in-flight block is discarded and not output.
- Reset values of outputs: in_ready=1, out_valid=0, busy=0, data_out=0.

## Timing
- Accept edge E0. RUN occupies edges E1..E_ROUNDS.
- out_valid rises after edge E_ROUNDS, i.e. ROUNDS cycles after the accept edge.
- Minimum block interval is ROUNDS+2 cycles (accept, ROUNDS rounds, handoff), when out_ready is held at 1.
- Outputs depend only on registered state; there are no combinational paths from input to output.
- Backpressure: out_valid and data_out hold with no time limit while out_ready=0.
- ROUNDS=1: DONE is reached on the first edge after accept.
- Deassertion of rst_n is assumed synchronised externally. The first accept is possible on the first edge with rst_n=1.

## Test plan
All scenarios use ROUNDS=4.
- XOR: key_vec=64'hAAAA_AAAA_AAAA_AAAA, data_in=0, mode=00 → data_out=64'h0000_0000_0000_0000 with out_valid high 4 cycles after accept; busy high throughout.
- ADD: key_vec=64'h1212_1212_1212_1212, data_in=64'h0000_0000_0000_00FF, mode=01 → data_out=64'h4E4E_4E4E_4E4E_4E4D (lane 0 wraps; no carry into lane 1).
- SUB: key_vec=all 8'hFF lanes, data_in=0, mode=10 → data_out=64'hFEFE_FEFE_FEFE_FEFE.
- ROTL: key_vec=all 8'h01 lanes, data_in=all 8'h81 lanes, mode=11 → total rotation 10 ≡ 2, data_out=64'h0606_0606_0606_0606.
- Backpressure: hold out_ready=0 for 10 cycles after DONE while pulsing in_valid with a new block:
  - out_valid stays 1, data_out stays stable, in_ready stays 0, and the new block is not accepted.
  - Then set out_ready=1 → IDLE next edge, in_ready=1, and the new block is accepted on the following edge.
- Reset mid-run: drop rst_n while r=2 → out_valid=0, busy=0, in_ready=1, data_out=0 immediately, with no edge needed.
  - After release, a fresh XOR block produces the correct result with no residue from the aborted block.

Source files
------------

// File: rtl/vec_round_cipher.sv
// Iterative per-lane byte cipher: ROUNDS rounds of XOR/ADD/SUB/ROTL against a
// captured key vector, one round per clock, valid/ready on both sides.
module vec_round_cipher #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] data_in_i,
  input  logic [63:0] key_vec_i,
  input  logic [1:0]  mode_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] data_out_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [63:0] work_q, work_d;
  logic [63:0] key_q, key_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  r_q, r_d;
  logic [63:0] round_out;

  function automatic logic [7:0] lane_op(input logic [7:0] w, input logic [7:0] k,
                                         input logic [1:0] m);
    logic [15:0] dbl;
    logic [7:0]  res;
    dbl = {w, w} << k[2:0];
    unique case (m)
      2'b00:   res = w ^ k;
      2'b01:   res = w + k;
      2'b10:   res = w - k;
      default: res = dbl[15:8];
    endcase
    return res;
  endfunction

  // Per-lane round key is key_i + r, wrapping within the byte.
  always_comb begin
    round_out = '0;
    for (int i = 0; i < 8; i++) begin
      round_out[8*i +: 8] = lane_op(work_q[8*i +: 8], 8'(key_q[8*i +: 8] + {4'b0, r_q}), mode_q);
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    key_d   = key_q;
    mode_d  = mode_q;
    r_d     = r_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          work_d  = data_in_i;
          key_d   = key_vec_i;
          mode_d  = mode_i;
          r_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d = round_out;
        if (r_q == LastRound) begin
          state_d = StDone;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      key_q   <= '0;
      mode_q  <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign data_out_o  = work_q;

endmodule

// File: tb/tb_vec_round_cipher.sv
// Directed bench for vec_round_cipher (ROUNDS=4): vector table plus backpressure
// and mid-run reset sequences.
module tb_vec_round_cipher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_in = '0;
  logic [63:0] key_vec = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vec_round_cipher #(.ROUNDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .data_in_i  (data_in),
    .key_vec_i  (key_vec),
    .mode_i     (mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .data_out_o (data_out),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [63:0] key;
    logic [1:0]  mode;
    logic [63:0] expected;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Waits for out_valid after an accept edge; returns cycles taken (bounded).
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check({name, " busy during run"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_block(input vec_t v);
    int cyc;
    @(negedge clk);
    data_in  = v.data;
    key_vec  = v.key;
    mode     = v.mode;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after accept: captured values must be used.
    in_valid = 1'b0;
    data_in  = ~v.data;
    key_vec  = ~v.key;
    mode     = ~v.mode;
    check({v.name, " in_ready after accept"}, 64'(in_ready), 64'd0);
    wait_done(v.name, cyc);
    check({v.name, " latency"}, 64'(cyc), 64'd4);
    check({v.name, " data_out"}, data_out, v.expected);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({v.name, " out_valid after handoff"}, 64'(out_valid), 64'd0);
    check({v.name, " in_ready after handoff"}, 64'(in_ready), 64'd1);
    check({v.name, " data_out held in idle"}, data_out, v.expected);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held;
    int          cyc;

    vecs[0] = '{"xor_aa",    64'h0,                   64'hAAAA_AAAA_AAAA_AAAA, 2'b00,
                64'h0000_0000_0000_0000};
    vecs[1] = '{"add_wrap",  64'h0000_0000_0000_00FF, 64'h1212_1212_1212_1212, 2'b01,
                64'h4E4E_4E4E_4E4E_4E4D};
    vecs[2] = '{"sub_ff",    64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 2'b10,
                64'hFEFE_FEFE_FEFE_FEFE};
    vecs[3] = '{"rotl_01",   64'h8181_8181_8181_8181, 64'h0101_0101_0101_0101, 2'b11,
                64'h0606_0606_0606_0606};
    vecs[4] = '{"xor_01_ff", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 2'b00,
                64'hFBFB_FBFB_FBFB_FBFB};
    vecs[5] = '{"rotl_08",   64'h8181_8181_8181_8181, 64'h0808_0808_0808_0808, 2'b11,
                64'h6060_6060_6060_6060};
    vecs[6] = '{"add_lane0", 64'h0,                   64'h0000_0000_0000_0010, 2'b01,
                64'h0606_0606_0606_0646};
    vecs[7] = '{"sub_10",    64'h1010_1010_1010_1010, 64'h0,                   2'b10,
                64'h0A0A_0A0A_0A0A_0A0A};

    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset data_out", data_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i]);
    end

    // Backpressure: DONE held for 10 cycles while a new block is offered.
    @(negedge clk);
    data_in = vecs[0].data; key_vec = vecs[0].key; mode = vecs[0].mode; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("bp first", cyc);
    check("bp first latency", 64'(cyc), 64'd4);
    check("bp first data_out", data_out, vecs[0].expected);
    held = data_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      data_in = vecs[1].data; key_vec = vecs[1].key; mode = vecs[1].mode;
      @(posedge clk); #1;
      check("bp out_valid held", 64'(out_valid), 64'd1);
      check("bp data_out stable", data_out, held);
      check("bp in_ready low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 64'(out_valid), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release busy", 64'(busy), 64'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp second accepted", 64'(busy), 64'd1);
    wait_done("bp second", cyc);
    check("bp second latency", 64'(cyc), 64'd4);
    check("bp second data_out", data_out, vecs[1].expected);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-run at r=2, asserted between clock edges.
    @(negedge clk);
    data_in = vecs[2].data; key_vec = vecs[2].key; mode = vecs[2].mode; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid-run busy before reset", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset in_ready", 64'(in_ready), 64'd1);
    check("async reset data_out", data_out, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_block(vecs[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
